sprite_motion_ctrl: RTL and testbench
=====================================

# sprite_motion_ctrl

Position source for the circle sprite renderer. It debounces four raw gamepad direction buttons and advances a sprite centre position once per video frame, clamped so the whole circle stays on-screen. It drives the renderer's `red_circle_x` / `red_circle_y` inputs and only changes them during vertical blanking, so a frame is never drawn with a torn position.

## Interface

**Parameters**
- `H_RES`, 640: visible width in pixels.
- `V_RES`, 480: visible height in pixels.
- `RADIUS`, 8: sprite radius. Must match the renderer.
- `STEP`, 2: pixels moved per frame at base speed.
- `FAST_FRAMES`, 30: consecutive held frames before the step doubles.
- `DEBOUNCE_CYCLES`, 1000000: stable-sample count to accept a button level (10 ms at 100 MHz).
- `X_INIT`, 320 and `Y_INIT`, 240: reset position.

**Ports**
- `CLK`  in  1: system clock. This is the only clock.
- `RST`  in  1: asynchronous, active-low reset.
- `btn_up`, `btn_down`, `btn_left`, `btn_right`  in  1 each: raw, asynchronous, active-high buttons.
- `frame_tick`  in  1: one-cycle pulse at the start of vertical blank.
- `sprite_x`  out  10: sprite centre x.
- `sprite_y`  out  9: sprite centre y.
- `pos_valid`  out  1: one-cycle pulse when a new position is committed.
- `moving`  out  1: high when the last update changed either coordinate.

## Operation
- **Button conditioning.** Each button passes through a 2-FF synchronizer, then a debouncer.
  - The debounced level flips only after `DEBOUNCE_CYCLES` consecutive synchronized samples that differ from it.
  - Any sample equal to the current debounced level resets that button's counter to 0.
- **Axis resolution.**
  - dx = right − left and dy = down − up, each in {−1, 0, +1}.
  - Opposite buttons pressed together resolve to 0 on that axis.
- **Hold counter** (6-bit, saturating at `FAST_FRAMES`).
  - Increments at each `frame_tick` while any debounced button is high.
  - Clears to 0 at a `frame_tick` when no button is high.
  - The step is `2*STEP` when the counter is at `FAST_FRAMES`, otherwise `STEP`.
- **State machine:** IDLE → UPD_X → UPD_Y → DONE → IDLE.
  - IDLE: waits for `frame_tick`. dx, dy, the step and the hold counter are captured on the tick cycle.
  - UPD_X: `sprite_x` ← clamp(`sprite_x` + dx·step, `RADIUS`, `H_RES`−1−`RADIUS`).
  - UPD_Y: `sprite_y` ← clamp(`sprite_y` + dy·step, `RADIUS`, `V_RES`−1−`RADIUS`).
  - DONE: `pos_valid` = 1. `moving` is set if either coordinate changed, otherwise cleared.
- **Arithmetic.** The sum is formed as 11-bit signed, clamped, then truncated to the output width.
  - A clamped result equal to the old value counts as "not changed".
- **`frame_tick` outside IDLE** is ignored and not queued.
- **Reset values.**
  - `sprite_x` = `X_INIT`, `sprite_y` = `Y_INIT`.
  - `pos_valid` = 0, `moving` = 0.
  - All debounced levels, debounce counters and the hold counter = 0. State = IDLE.
- **Reset asserted mid-update** returns all of the above immediately. No partial commit survives.

## Timing
- `frame_tick` is sampled high in cycle T.
  - The new `sprite_x` is visible from T+2.
  - The new `sprite_y` is visible from T+3.
  - `pos_valid` is high for exactly cycle T+3 and `moving` updates at T+4.
  - IDLE resumes at T+4.
- Outputs are registered and change only in UPD_X, UPD_Y and DONE. They are stable for the rest of the frame.
- Button-to-debounced latency is 2 synchronizer cycles plus `DEBOUNCE_CYCLES`. A pulse shorter than `DEBOUNCE_CYCLES` is rejected.
- A button change lands in the update only if its debounced level has changed by cycle T.

## Structure
- **Shared package** `sprite_pkg`:
  - The state enum (IDLE, UPD_X, UPD_Y, DONE).
  - `H_RES` and `V_RES` defaults, shared with the VGA timing block.
  - The default `RADIUS`, shared with the renderer.
- **Sub-module** `btn_debounce`, instantiated 4×: synchronizer, counter and debounced-level register. Parameter `DEBOUNCE_CYCLES`.
- The top level holds axis resolution, the hold counter, the FSM and the clamp.

## Test plan
All scenarios use `DEBOUNCE_CYCLES` = 4 and the other parameters at default.
- **Reset:** release `RST` → `sprite_x`=320, `sprite_y`=240, `pos_valid`=0, `moving`=0. Ticks with no buttons give `pos_valid` pulses with the position unchanged and `moving`=0.
- **Debounce:** toggle `btn_right` high for 3 cycles → no effect on the next tick. Hold it for 10 cycles, then tick → `sprite_x`=322 at T+2, `sprite_y`=240, `moving`=1.
- **Clamp and conflict:** from the left edge, hold `btn_left` for 200 ticks → `sprite_x` settles at 8 and `moving` returns to 0. Press `btn_up` with `btn_down` → `sprite_y` is unchanged.
- **Acceleration:** hold `btn_down` for 35 ticks → per-tick deltas of 2 for ticks 1–30, then 4 for ticks 31–35. `sprite_y` never exceeds 471. Release and tick again → the hold counter clears.
- **Tick collision:** pulse `frame_tick` at T and again at T+2 → exactly one `pos_valid` and one step applied.
- **Reset mid-update:** assert `RST` in UPD_X → outputs return to 320/240/0/0 at once, and normal updates resume after release.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite motion controller, the VGA timing block and the circle renderer.
package sprite_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_UPD_X = 2'd1,
    ST_UPD_Y = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int H_RES_DEF  = 640;
  localparam int V_RES_DEF  = 480;
  localparam int RADIUS_DEF = 8;
  localparam int X_W        = 10;
  localparam int Y_W        = 9;

  // Coordinates are evaluated in an 11-bit signed space so an underflow past 0 stays negative.
  function automatic logic signed [10:0] clamp_coord(input logic signed [10:0] v,
                                                    input logic signed [10:0] lo,
                                                    input logic signed [10:0] hi);
    logic signed [10:0] r;
    if (v < lo) begin
      r = lo;
    end else if (v > hi) begin
      r = hi;
    end else begin
      r = v;
    end
    return r;
  endfunction

endpackage

// File: rtl/sprite_motion_ctrl_if.sv
// Gamepad/frame inputs and sprite position outputs of the motion controller.
interface sprite_motion_ctrl_if;
  import sprite_pkg::*;

  logic           btn_up;
  logic           btn_down;
  logic           btn_left;
  logic           btn_right;
  logic           frame_tick;
  logic [X_W-1:0] sprite_x;
  logic [Y_W-1:0] sprite_y;
  logic           pos_valid;
  logic           moving;

  modport master (
    output btn_up, btn_down, btn_left, btn_right, frame_tick,
    input  sprite_x, sprite_y, pos_valid, moving
  );

  modport slave (
    input  btn_up, btn_down, btn_left, btn_right, frame_tick,
    output sprite_x, sprite_y, pos_valid, moving
  );
endinterface

// File: rtl/btn_debounce.sv
// Two-flop synchronizer followed by a counting debouncer for one raw button.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic btn_level
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             sync1_r;
  logic             sync2_r;
  logic [CNT_W-1:0] cnt_r;
  logic             level_r;

  // Bring the asynchronous button into the clock domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= btn_raw;
      sync2_r <= sync1_r;
    end
  end

  // Flip the accepted level only after an unbroken run of differing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r   <= '0;
      level_r <= 1'b0;
    end else if (sync2_r == level_r) begin
      cnt_r <= '0;
    end else if (cnt_r == CNT_LAST) begin
      cnt_r   <= '0;
      level_r <= sync2_r;
    end else begin
      cnt_r <= cnt_r + CNT_ONE;
    end
  end

  assign btn_level = level_r;

endmodule

// File: rtl/sprite_motion_ctrl.sv
// Debounces the gamepad and advances the clamped sprite centre once per frame during vertical blank.
module sprite_motion_ctrl
  import sprite_pkg::*;
#(
  parameter int H_RES           = H_RES_DEF,
  parameter int V_RES           = V_RES_DEF,
  parameter int RADIUS          = RADIUS_DEF,
  parameter int STEP            = 2,
  parameter int FAST_FRAMES     = 30,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int X_INIT          = 320,
  parameter int Y_INIT          = 240
) (
  input  logic                 CLK,
  input  logic                 RST,
  sprite_motion_ctrl_if.slave  bus
);

  localparam logic [5:0]         FAST_CNT  = 6'(FAST_FRAMES);
  localparam logic signed [10:0] STEP_BASE = 11'(STEP);
  localparam logic signed [10:0] STEP_FAST = 11'(2 * STEP);
  localparam logic signed [10:0] LO_LIM    = 11'(RADIUS);
  localparam logic signed [10:0] X_HI_LIM  = 11'(H_RES - 1 - RADIUS);
  localparam logic signed [10:0] Y_HI_LIM  = 11'(V_RES - 1 - RADIUS);
  localparam logic [X_W-1:0]     X_RST     = X_W'(X_INIT);
  localparam logic [Y_W-1:0]     Y_RST     = Y_W'(Y_INIT);

  logic up_db_s, down_db_s, left_db_s, right_db_s;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
    .clk(CLK), .rst_n(RST), .btn_raw(bus.btn_up), .btn_level(up_db_s)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
    .clk(CLK), .rst_n(RST), .btn_raw(bus.btn_down), .btn_level(down_db_s)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_left (
    .clk(CLK), .rst_n(RST), .btn_raw(bus.btn_left), .btn_level(left_db_s)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_right (
    .clk(CLK), .rst_n(RST), .btn_raw(bus.btn_right), .btn_level(right_db_s)
  );

  state_t                state_r;
  logic [X_W-1:0]        sprite_x_r;
  logic [Y_W-1:0]        sprite_y_r;
  logic                  pos_valid_r;
  logic                  moving_r;
  logic                  changed_r;
  logic [5:0]            hold_r;
  logic signed [2:0]     dx_r;
  logic signed [2:0]     dy_r;
  logic signed [10:0]    step_r;

  logic signed [2:0]     dx_s;
  logic signed [2:0]     dy_s;
  logic                  any_btn_s;
  logic signed [10:0]    step_s;
  logic signed [10:0]    sum_x_s;
  logic signed [10:0]    sum_y_s;
  logic signed [10:0]    clamp_x_s;
  logic signed [10:0]    clamp_y_s;
  logic [X_W-1:0]        new_x_s;
  logic [Y_W-1:0]        new_y_s;

  // Opposite buttons cancel; the step doubles once the hold counter has saturated.
  always_comb begin
    dx_s      = $signed({2'b00, right_db_s}) - $signed({2'b00, left_db_s});
    dy_s      = $signed({2'b00, down_db_s}) - $signed({2'b00, up_db_s});
    any_btn_s = up_db_s | down_db_s | left_db_s | right_db_s;
    if (hold_r == FAST_CNT) begin
      step_s = STEP_FAST;
    end else begin
      step_s = STEP_BASE;
    end
  end

  // Candidate coordinates from the captured direction and step, clamped to keep the circle on-screen.
  always_comb begin
    case (dx_r)
      3'sb001: sum_x_s = $signed({1'b0, sprite_x_r}) + step_r;
      3'sb111: sum_x_s = $signed({1'b0, sprite_x_r}) - step_r;
      default: sum_x_s = $signed({1'b0, sprite_x_r});
    endcase
    case (dy_r)
      3'sb001: sum_y_s = $signed({2'b00, sprite_y_r}) + step_r;
      3'sb111: sum_y_s = $signed({2'b00, sprite_y_r}) - step_r;
      default: sum_y_s = $signed({2'b00, sprite_y_r});
    endcase
    clamp_x_s = clamp_coord(sum_x_s, LO_LIM, X_HI_LIM);
    clamp_y_s = clamp_coord(sum_y_s, LO_LIM, Y_HI_LIM);
    new_x_s   = clamp_x_s[X_W-1:0];
    new_y_s   = clamp_y_s[Y_W-1:0];
  end

  // Per-frame update sequence; outputs only move in UPD_X, UPD_Y and DONE.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r     <= ST_IDLE;
      sprite_x_r  <= X_RST;
      sprite_y_r  <= Y_RST;
      pos_valid_r <= 1'b0;
      moving_r    <= 1'b0;
      changed_r   <= 1'b0;
      hold_r      <= 6'd0;
      dx_r        <= 3'sd0;
      dy_r        <= 3'sd0;
      step_r      <= 11'sd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          pos_valid_r <= 1'b0;
          if (bus.frame_tick) begin
            dx_r    <= dx_s;
            dy_r    <= dy_s;
            step_r  <= step_s;
            state_r <= ST_UPD_X;
            if (!any_btn_s) begin
              hold_r <= 6'd0;
            end else if (hold_r >= FAST_CNT) begin
              hold_r <= FAST_CNT;
            end else begin
              hold_r <= hold_r + 6'd1;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_UPD_X: begin
          sprite_x_r <= new_x_s;
          changed_r  <= (new_x_s != sprite_x_r);
          state_r    <= ST_UPD_Y;
        end
        ST_UPD_Y: begin
          sprite_y_r  <= new_y_s;
          changed_r   <= changed_r | (new_y_s != sprite_y_r);
          pos_valid_r <= 1'b1;
          state_r     <= ST_DONE;
        end
        ST_DONE: begin
          pos_valid_r <= 1'b0;
          moving_r    <= changed_r;
          state_r     <= ST_IDLE;
        end
        default: begin
          pos_valid_r <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.sprite_x  = sprite_x_r;
  assign bus.sprite_y  = sprite_y_r;
  assign bus.pos_valid = pos_valid_r;
  assign bus.moving    = moving_r;

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Self-checking bench for sprite_motion_ctrl: vector table, scoreboard on pos_valid, hand-written corner sequences.
module tb_sprite_motion_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sprite_motion_ctrl_if bus ();

  sprite_motion_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus.slave)
  );

  typedef struct {
    int   x;
    int   y;
    logic mv;
  } exp_t;

  typedef struct {
    logic u, d, l, r;
    int   ticks;
    int   ex, ey;
    logic emv;
  } vec_t;

  exp_t sb_q[$];
  vec_t vt[6];

  int n_vec = 0;
  int n_bad = 0;
  int pv_count = 0;

  int   mx = 320, my = 240, mhold = 0;
  logic mu = 1'b0, md = 1'b0, ml = 1'b0, mr = 1'b0;
  logic mv_pending = 1'b0;
  logic exp_mv = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int clampi(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  // Reference model of one frame update; pushes the expected committed position.
  task automatic model_push();
    int   step, nx, ny;
    exp_t e;
    step  = (mhold == 30) ? 4 : 2;
    nx    = clampi(mx + (int'(mr) - int'(ml)) * step, 8, 631);
    ny    = clampi(my + (int'(md) - int'(mu)) * step, 8, 471);
    e.x   = nx;
    e.y   = ny;
    e.mv  = (nx != mx) || (ny != my);
    mhold = (mu | md | ml | mr) ? ((mhold >= 30) ? 30 : mhold + 1) : 0;
    mx    = nx;
    my    = ny;
    sb_q.push_back(e);
  endtask

  // Scoreboard: pop on pos_valid, then check moving one cycle later.
  always @(negedge clk) begin
    exp_t e;
    if (mv_pending) begin
      check("moving", {31'd0, bus.moving}, {31'd0, exp_mv});
      mv_pending <= 1'b0;
    end
    if (bus.pos_valid === 1'b1) begin
      pv_count <= pv_count + 1;
      if (sb_q.size() == 0) begin
        check("unexpected pos_valid", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("sb sprite_x", {22'd0, bus.sprite_x}, e.x);
        check("sb sprite_y", {23'd0, bus.sprite_y}, e.y);
        exp_mv     <= e.mv;
        mv_pending <= 1'b1;
      end
    end
  end

  task automatic set_btns(input logic u, input logic d, input logic l, input logic r);
    @(negedge clk);
    bus.btn_up = u; bus.btn_down = d; bus.btn_left = l; bus.btn_right = r;
    repeat (8) @(negedge clk);
    mu = u; md = d; ml = l; mr = r;
  endtask

  // One frame with cycle-accurate checks of when x, y and pos_valid change.
  task automatic do_tick();
    int ox, oy;
    ox = mx; oy = my;
    model_push();
    @(negedge clk) bus.frame_tick = 1'b1;
    @(negedge clk) bus.frame_tick = 1'b0;
    check("x held at T+1", {22'd0, bus.sprite_x}, ox);
    @(negedge clk);
    check("x new at T+2", {22'd0, bus.sprite_x}, mx);
    check("y held at T+2", {23'd0, bus.sprite_y}, oy);
    @(negedge clk);
    check("y new at T+3", {23'd0, bus.sprite_y}, my);
    check("pos_valid at T+3", {31'd0, bus.pos_valid}, 32'd1);
    @(negedge clk);
    check("pos_valid low T+4", {31'd0, bus.pos_valid}, 32'd0);
    @(negedge clk);
  endtask

  initial begin
    int prev, maxy, pv0;
    vec_t v;

    vt[0] = '{u:1'b0, d:1'b0, l:1'b0, r:1'b0, ticks:2, ex:322, ey:240, emv:1'b0};
    vt[1] = '{u:1'b0, d:1'b0, l:1'b0, r:1'b1, ticks:3, ex:328, ey:240, emv:1'b1};
    vt[2] = '{u:1'b1, d:1'b1, l:1'b0, r:1'b0, ticks:2, ex:328, ey:240, emv:1'b0};
    vt[3] = '{u:1'b1, d:1'b0, l:1'b1, r:1'b0, ticks:2, ex:324, ey:236, emv:1'b1};
    vt[4] = '{u:1'b0, d:1'b0, l:1'b0, r:1'b0, ticks:1, ex:324, ey:236, emv:1'b0};
    vt[5] = '{u:1'b0, d:1'b1, l:1'b0, r:1'b1, ticks:1, ex:326, ey:238, emv:1'b1};

    bus.btn_up = 1'b0; bus.btn_down = 1'b0; bus.btn_left = 1'b0; bus.btn_right = 1'b0;
    bus.frame_tick = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset x", {22'd0, bus.sprite_x}, 32'd320);
    check("reset y", {23'd0, bus.sprite_y}, 32'd240);
    check("reset pos_valid", {31'd0, bus.pos_valid}, 32'd0);
    check("reset moving", {31'd0, bus.moving}, 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    do_tick();
    do_tick();

    // Debounce: a 3-cycle pulse is rejected, a 10-cycle hold is accepted
    bus.btn_right = 1'b1;
    repeat (3) @(negedge clk);
    bus.btn_right = 1'b0;
    repeat (8) @(negedge clk);
    do_tick();
    check("short pulse x", {22'd0, bus.sprite_x}, 32'd320);
    bus.btn_right = 1'b1;
    repeat (10) @(negedge clk);
    mr = 1'b1;
    do_tick();
    check("debounced x", {22'd0, bus.sprite_x}, 32'd322);
    check("debounced y", {23'd0, bus.sprite_y}, 32'd240);
    check("debounced moving", {31'd0, bus.moving}, 32'd1);
    set_btns(1'b0, 1'b0, 1'b0, 1'b0);

    // Table-driven vectors
    for (int i = 0; i < 6; i++) begin
      v = vt[i];
      set_btns(v.u, v.d, v.l, v.r);
      for (int k = 0; k < v.ticks; k++) do_tick();
      @(negedge clk);
      check($sformatf("vec%0d x", i), {22'd0, bus.sprite_x}, v.ex);
      check($sformatf("vec%0d y", i), {23'd0, bus.sprite_y}, v.ey);
      check($sformatf("vec%0d moving", i), {31'd0, bus.moving}, {31'd0, v.emv});
    end

    // Acceleration: 30 ticks at step 2, then step 4
    set_btns(1'b0, 1'b0, 1'b0, 1'b0);
    do_tick();
    set_btns(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 35; i++) begin
      prev = bus.sprite_y;
      do_tick();
      check($sformatf("accel delta tick%0d", i + 1), bus.sprite_y - prev, (i < 30) ? 2 : 4);
    end
    check("accel final y", {23'd0, bus.sprite_y}, 32'd318);

    // Release clears the hold counter: next press steps by 2 again
    set_btns(1'b0, 1'b0, 1'b0, 1'b0);
    do_tick();
    set_btns(1'b0, 1'b1, 1'b0, 1'b0);
    prev = bus.sprite_y;
    do_tick();
    check("hold cleared delta", bus.sprite_y - prev, 32'd2);

    // Bottom clamp
    maxy = 0;
    for (int i = 0; i < 200; i++) begin
      do_tick();
      if (bus.sprite_y > maxy) maxy = bus.sprite_y;
    end
    check("max y", maxy, 32'd471);
    check("bottom clamp y", {23'd0, bus.sprite_y}, 32'd471);
    check("bottom clamp moving", {31'd0, bus.moving}, 32'd0);

    // Left clamp
    set_btns(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 200; i++) do_tick();
    check("left clamp x", {22'd0, bus.sprite_x}, 32'd8);
    check("left clamp moving", {31'd0, bus.moving}, 32'd0);

    // Tick collision: second tick during UPD_Y is dropped
    set_btns(1'b0, 1'b0, 1'b0, 1'b0);
    do_tick();
    set_btns(1'b0, 1'b0, 1'b0, 1'b1);
    pv0 = pv_count;
    model_push();
    @(negedge clk) bus.frame_tick = 1'b1;
    @(negedge clk) bus.frame_tick = 1'b0;
    @(negedge clk) bus.frame_tick = 1'b1;
    @(negedge clk) bus.frame_tick = 1'b0;
    repeat (8) @(negedge clk);
    check("collision pos_valid count", pv_count - pv0, 32'd1);
    check("collision x", {22'd0, bus.sprite_x}, 32'd10);

    // Reset asserted while in UPD_X
    @(negedge clk) bus.frame_tick = 1'b1;
    @(negedge clk) bus.frame_tick = 1'b0;
    rst = 1'b0;
    #1;
    check("mid reset x", {22'd0, bus.sprite_x}, 32'd320);
    check("mid reset y", {23'd0, bus.sprite_y}, 32'd240);
    check("mid reset pos_valid", {31'd0, bus.pos_valid}, 32'd0);
    check("mid reset moving", {31'd0, bus.moving}, 32'd0);
    repeat (3) @(negedge clk);
    check("mid reset x held", {22'd0, bus.sprite_x}, 32'd320);
    rst = 1'b1;
    mx = 320; my = 240; mhold = 0;
    repeat (8) @(negedge clk);
    do_tick();
    check("post reset x", {22'd0, bus.sprite_x}, 32'd322);
    check("post reset moving", {31'd0, bus.moving}, 32'd1);

    repeat (4) @(negedge clk);
    check("scoreboard drained", sb_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
